// File: rtl/dram_access_ctrl.sv
// rtl/dram_access_ctrl.sv - request/response master for the 256x16 single-port data RAM
module dram_access_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              wr_done,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

   localparam logic [LEN_W:0]  ONE_BEAT = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   state_t r_state;
   state_t w_next;

   logic [ADDR_W-1:0] r_mem_address;
   logic [DATA_W-1:0] r_mem_data;
   logic              r_mem_wren;
   logic              r_wr_done;
   logic [LEN_W:0]    r_beats_left;
   logic              r_inflight;
   logic              r_inflight_last;

   // two-entry response buffer, head/tail pointers toggle between slots
   logic [DATA_W-1:0] r_buf_data [2];
   logic              r_buf_last [2];
   logic              r_head;
   logic              r_tail;
   logic [1:0]        r_count;

   logic              w_accept;
   logic              w_pop;
   logic              w_push;
   logic              w_issue;
   logic              w_last_issue;
   logic [2:0]        w_room;

   // a word fetched last cycle always lands in the buffer; the issue rule
   // guarantees it has a free slot, counting words still in flight
   assign w_pop        = (r_count != 2'd0) && rsp_ready;
   assign w_push       = r_inflight;
   assign w_room       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue      = (r_state == S_READ) && (r_beats_left != '0) && (w_room < 3'd2);
   assign w_last_issue = w_issue && (r_beats_left == ONE_BEAT);
   assign w_accept     = req_valid && req_ready;

   assign rsp_valid   = (r_count != 2'd0);
   assign rsp_data    = r_buf_data[r_head];
   assign rsp_last    = r_buf_last[r_head];
   assign busy        = (r_state != S_IDLE) || (r_count != 2'd0);
   assign wr_done     = r_wr_done;
   assign mem_address = r_mem_address;
   assign mem_data    = r_mem_data;
   assign mem_wren    = r_mem_wren;

   // state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // next-state and request handshake
   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = req_we ? S_WRITE : S_READ;
         end
         S_WRITE: w_next = S_IDLE;
         S_READ:  if (w_last_issue) w_next = S_DRAIN;
         S_DRAIN: if (w_pop && rsp_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // RAM port registers, burst counter and in-flight tracking
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_mem_address   <= '0;
         r_mem_data      <= '0;
         r_mem_wren      <= 1'b0;
         r_wr_done       <= 1'b0;
         r_beats_left    <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_mem_wren      <= w_accept && req_we;
         r_wr_done       <= (r_state == S_WRITE);
         r_inflight      <= w_issue;
         r_inflight_last <= w_last_issue;
         if (w_accept) begin
            r_mem_address <= req_addr;
            if (req_we) r_mem_data   <= req_wdata;
            else        r_beats_left <= {1'b0, req_len} + ONE_BEAT;
         end else if (w_issue) begin
            r_mem_address <= r_mem_address + ADDR_ONE;
            r_beats_left  <= r_beats_left - ONE_BEAT;
         end
      end
   end

   // response FIFO: push RAM q one cycle after its issue, pop on handshake
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_buf_data[0] <= '0;
         r_buf_data[1] <= '0;
         r_buf_last[0] <= 1'b0;
         r_buf_last[1] <= 1'b0;
         r_head        <= 1'b0;
         r_tail        <= 1'b0;
         r_count       <= 2'd0;
      end else begin
         if (w_push) begin
            r_buf_data[r_tail] <= mem_q;
            r_buf_last[r_tail] <= r_inflight_last;
            r_tail             <= ~r_tail;
         end
         if (w_pop) r_head <= ~r_head;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_access_ctrl.sv
// tb/tb_dram_access_ctrl.sv - scoreboard testbench for dram_access_ctrl
module tb_dram_access_ctrl;

   logic        clock;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic [3:0]  req_len;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_last;
   logic        wr_done;
   logic        busy;
   logic [7:0]  mem_address;
   logic [15:0] mem_data;
   logic        mem_wren;
   logic [15:0] mem_q;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   logic [16:0] exp_q [$];

   dram_access_ctrl dut (
      .clock(clock), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .wr_done(wr_done), .busy(busy),
      .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
      .mem_q(mem_q)
   );

   // RAM model: registered address/data/wren, unregistered q
   logic [15:0] ram [256];
   logic [7:0]  ram_addr_q;
   initial for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
   initial ram_addr_q = 8'h00;
   always @(posedge clock) begin
      if (mem_wren) ram[mem_address] <= mem_data;
      ram_addr_q <= mem_address;
   end
   assign mem_q = ram[ram_addr_q];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_push(input logic [15:0] d, input logic last);
      exp_q.push_back({last, d});
   endtask

   // monitor: every accepted response word is compared with the scoreboard head
   always @(negedge clock) begin
      if (resetn && rsp_valid && rsp_ready) begin
         logic [16:0] e;
         n_pops++;
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
            check("rsp_last", 32'(rsp_last), 32'(e[16]));
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      check({tag, "_rsp_last"}, 32'(rsp_last), 32'd0);
      check({tag, "_wr_done"}, 32'(wr_done), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
      check({tag, "_mem_data"}, 32'(mem_data), 32'd0);
      check({tag, "_mem_wren"}, 32'(mem_wren), 32'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check("wait_ready_timeout", 32'(req_ready), 32'd1);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [15:0] d);
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      @(posedge clock); #1;
      req_valid = 1'b0; req_we = 1'b0;
      check("wr_c1_wren", 32'(mem_wren), 32'd1);
      check("wr_c1_addr", 32'(mem_address), 32'(a));
      check("wr_c1_data", 32'(mem_data), 32'(d));
      check("wr_c1_ready", 32'(req_ready), 32'd0);
      check("wr_c1_done", 32'(wr_done), 32'd0);
      @(posedge clock); #1;
      check("wr_c2_wren", 32'(mem_wren), 32'd0);
      check("wr_c2_done", 32'(wr_done), 32'd1);
      check("wr_c2_ready", 32'(req_ready), 32'd1);
   endtask

   // read burst with rsp_ready high; checks address sequence and latency
   task automatic do_read(input logic [7:0] a, input logic [3:0] len);
      int last_k;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = len;
      @(posedge clock); #1;
      req_valid = 1'b0;
      check("rd_c1_ready", 32'(req_ready), 32'd0);
      last_k = int'(len) + 3;
      for (int k = 1; k <= last_k; k++) begin
         if (k <= int'(len) + 1)
            check("rd_addr", 32'(mem_address), 32'(8'(a + 8'(k - 1))));
         check("rd_valid", 32'(rsp_valid), (k >= 3) ? 32'd1 : 32'd0);
         @(posedge clock); #1;
      end
      check("rd_end_ready", 32'(req_ready), 32'd1);
      check("rd_end_valid", 32'(rsp_valid), 32'd0);
      check("rd_end_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int cyc;
      int bad;
      int base;
      resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
      req_wdata = 16'h0000; req_len = 4'h0; rsp_ready = 1'b1;
      #3;
      check_reset_vals("rst0");
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
      @(posedge clock); #1;
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // write then read back, read issued in the wr_done cycle
      do_write(8'h10, 16'h1234);
      exp_push(16'h1234, 1'b1);
      do_read(8'h10, 4'd0);

      // wrap-around burst
      do_write(8'hFE, 16'hA0A0);
      do_write(8'hFF, 16'hB1B1);
      do_write(8'h00, 16'hC2C2);
      do_write(8'h01, 16'hD3D3);
      exp_push(16'hA0A0, 1'b0);
      exp_push(16'hB1B1, 1'b0);
      exp_push(16'hC2C2, 1'b0);
      exp_push(16'hD3D3, 1'b1);
      do_read(8'hFE, 4'd3);

      // backpressure with a write held pending during the burst
      for (int i = 0; i < 8; i++) do_write(8'h20 + 8'(i), 16'h5500 + 16'(i));
      for (int i = 0; i < 8; i++) exp_push(16'h5500 + 16'(i), i == 7);
      base = n_pops;
      rsp_ready = 1'b0;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20; req_len = 4'd7;
      @(posedge clock); #1;
      req_valid = 1'b0;
      cyc = 1;
      while (!rsp_valid && cyc < 50) begin
         @(posedge clock); #1;
         cyc++;
      end
      check("bp_first_latency", 32'(cyc), 32'd3);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30; req_wdata = 16'h7777;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (req_ready || mem_wren) bad++;
         @(posedge clock); #1;
      end
      check("bp_reject", 32'(bad), 32'd0);
      check("bp_stall_addr", 32'(mem_address), 32'h22);
      check("bp_stall_valid", 32'(rsp_valid), 32'd1);
      check("bp_stall_head", 32'(rsp_data), 32'h5500);
      rsp_ready = 1'b1;
      bad = 0;
      cyc = 0;
      while (!req_ready && cyc < 100) begin
         if (mem_wren) bad++;
         @(posedge clock); #1;
         cyc++;
      end
      check("bp_drain_timeout", 32'(req_ready), 32'd1);
      check("bp_no_early_wren", 32'(bad), 32'd0);
      check("bp_pops", 32'(n_pops - base), 32'd8);
      @(posedge clock); #1;
      req_valid = 1'b0; req_we = 1'b0;
      check("pend_wr_wren", 32'(mem_wren), 32'd1);
      check("pend_wr_addr", 32'(mem_address), 32'h30);
      check("pend_wr_data", 32'(mem_data), 32'h7777);
      @(posedge clock); #1;
      check("pend_wr_done", 32'(wr_done), 32'd1);
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         if (mem_wren) bad++;
         @(posedge clock); #1;
      end
      check("pend_wr_once", 32'(bad), 32'd0);
      exp_push(16'h7777, 1'b1);
      do_read(8'h30, 4'd0);

      // reset in the middle of a long burst
      for (int i = 0; i < 4; i++) exp_push(16'h5500 + 16'(i), 1'b0);
      base = n_pops;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20; req_len = 4'd15;
      @(posedge clock); #1;
      req_valid = 1'b0;
      cyc = 0;
      while ((n_pops - base) < 4 && cyc < 100) begin
         @(posedge clock); #1;
         cyc++;
      end
      check("mid_pops", 32'(n_pops - base), 32'd4);
      check("mid_busy_before", 32'(busy), 32'd1);
      #1 resetn = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      exp_q.delete();
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;
      exp_push(16'h1234, 1'b1);
      do_read(8'h10, 4'd0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
